// File: rtl/pc_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Program counter with flag-driven branch decisions and a small
//               return-address stack for CALL/RET.
// Revision    : 1.0
// ============================================================================
module pc_branch_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clk,
    input  logic                pc_rst,
    input  logic                pc_en,
    input  logic [2:0]          pc_op,
    input  logic [PC_WIDTH-1:0] pc_target_in,
    input  logic                flag_c_in,
    input  logic                flag_z_in,
    input  logic                flag_b_in,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                pc_taken,
    output logic                stack_ovf,
    output logic                stack_unf
);

    localparam int c_IDX_W = $clog2(STACK_DEPTH);
    localparam int c_SP_W  = $clog2(STACK_DEPTH + 1);

    localparam logic [c_SP_W-1:0] c_SP_FULL = c_SP_W'(STACK_DEPTH);

    localparam logic [2:0] c_OP_INC  = 3'b000;
    localparam logic [2:0] c_OP_JMP  = 3'b001;
    localparam logic [2:0] c_OP_JC   = 3'b010;
    localparam logic [2:0] c_OP_JZ   = 3'b011;
    localparam logic [2:0] c_OP_JB   = 3'b100;
    localparam logic [2:0] c_OP_JNZ  = 3'b101;
    localparam logic [2:0] c_OP_CALL = 3'b110;
    localparam logic [2:0] c_OP_RET  = 3'b111;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_taken;
    logic                r_ovf;
    logic                r_unf;
    logic [c_SP_W-1:0]   r_sp;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic                w_taken;
    logic                w_push;
    logic                w_pop;
    logic                w_set_ovf;
    logic                w_set_unf;
    logic                w_full;
    logic                w_empty;
    logic [c_IDX_W-1:0]  w_push_idx;
    logic [c_IDX_W-1:0]  w_top_idx;

    // Pointer counts 0..STACK_DEPTH; it is also the slot index for the next push.
    assign w_pc_inc   = r_pc + 1'b1;
    assign w_full     = (r_sp == c_SP_FULL);
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = r_sp[c_IDX_W-1:0];
    assign w_top_idx  = c_IDX_W'(r_sp - 1'b1);

    always_comb begin
        w_next_pc = w_pc_inc;
        w_taken   = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        case (pc_op)
            c_OP_INC: ;
            c_OP_JMP: begin
                w_next_pc = pc_target_in;
                w_taken   = 1'b1;
            end
            c_OP_JC: if (flag_c_in) begin
                w_next_pc = pc_target_in;
                w_taken   = 1'b1;
            end
            c_OP_JZ: if (flag_z_in) begin
                w_next_pc = pc_target_in;
                w_taken   = 1'b1;
            end
            c_OP_JB: if (flag_b_in) begin
                w_next_pc = pc_target_in;
                w_taken   = 1'b1;
            end
            c_OP_JNZ: if (!flag_z_in) begin
                w_next_pc = pc_target_in;
                w_taken   = 1'b1;
            end
            c_OP_CALL: begin
                if (!w_full) begin
                    w_next_pc = pc_target_in;
                    w_taken   = 1'b1;
                    w_push    = 1'b1;
                end else begin
                    w_set_ovf = 1'b1;
                end
            end
            c_OP_RET: begin
                if (!w_empty) begin
                    w_next_pc = r_stack[w_top_idx];
                    w_taken   = 1'b1;
                    w_pop     = 1'b1;
                end else begin
                    w_set_unf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!pc_rst) begin
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_sp    <= '0;
        end else if (pc_en) begin
            r_pc    <= w_next_pc;
            r_taken <= w_taken;
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
            if (w_push)
                r_sp <= r_sp + 1'b1;
            else if (w_pop)
                r_sp <= r_sp - 1'b1;
        end else begin
            r_taken <= 1'b0;
        end
    end

    // Stack storage carries no reset; emptiness is tracked solely by r_sp.
    always_ff @(posedge clk) begin
        if (pc_rst && pc_en && w_push)
            r_stack[w_push_idx] <= w_pc_inc;
    end

    assign pc_out    = r_pc;
    assign pc_taken  = r_taken;
    assign stack_ovf = r_ovf;
    assign stack_unf = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Directed bench for pc_branch_unit with a queue-based model.
// Revision    : 1.0
// ============================================================================
module tb_pc_branch_unit;

    localparam int PW    = 8;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << PW) - 1;

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, JC = 3'd2, JZ = 3'd3,
                           JB  = 3'd4, JNZ = 3'd5, CALL = 3'd6, RET = 3'd7;

    logic          clk = 1'b0;
    logic          pc_rst = 1'b0;
    logic          pc_en = 1'b0;
    logic [2:0]    pc_op = 3'd0;
    logic [PW-1:0] pc_target_in = '0;
    logic          flag_c_in = 1'b0;
    logic          flag_z_in = 1'b0;
    logic          flag_b_in = 1'b0;
    logic [PW-1:0] pc_out;
    logic          pc_taken;
    logic          stack_ovf;
    logic          stack_unf;

    int n_cmp = 0;
    int n_err = 0;

    pc_branch_unit #(.PC_WIDTH(PW), .STACK_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .pc_rst       (pc_rst),
        .pc_en        (pc_en),
        .pc_op        (pc_op),
        .pc_target_in (pc_target_in),
        .flag_c_in    (flag_c_in),
        .flag_z_in    (flag_z_in),
        .flag_b_in    (flag_b_in),
        .pc_out       (pc_out),
        .pc_taken     (pc_taken),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf)
    );

    always #5 clk = ~clk;

    // Reference model: integer PC and a queue acting as the return stack.
    int m_pc = 0;
    bit m_taken = 0, m_ovf = 0, m_unf = 0, m_valid = 0;
    int m_stack[$];

    always @(posedge clk) begin
        int inc;
        bit jump;
        if (!pc_rst) begin
            m_pc = 0; m_taken = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
            m_valid = 1;
        end else if (pc_en) begin
            inc  = (m_pc + 1) & MASK;
            jump = 0;
            m_taken = 0;
            m_pc = inc;
            case (pc_op)
                JMP:  jump = 1;
                JC:   jump = flag_c_in;
                JZ:   jump = flag_z_in;
                JB:   jump = flag_b_in;
                JNZ:  jump = !flag_z_in;
                CALL: if (m_stack.size() < DEPTH) begin
                          m_stack.push_back(inc);
                          jump = 1;
                      end else m_ovf = 1;
                RET:  if (m_stack.size() > 0) begin
                          m_pc = m_stack.pop_back();
                          m_taken = 1;
                      end else m_unf = 1;
                default: ;
            endcase
            if (jump) begin
                m_pc = int'(pc_target_in);
                m_taken = 1;
            end
        end else begin
            m_taken = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp++;
            if (pc_out !== m_pc[PW-1:0] || pc_taken !== m_taken ||
                stack_ovf !== m_ovf || stack_unf !== m_unf) begin
                n_err++;
                $display("FAIL model t=%0t: got pc=%02h tk=%b ovf=%b unf=%b, want pc=%02h tk=%b ovf=%b unf=%b",
                         $time, pc_out, pc_taken, stack_ovf, stack_unf,
                         m_pc[PW-1:0], m_taken, m_ovf, m_unf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [2:0] op, input int tgt,
                        input logic c = 1'b0, input logic z = 1'b0, input logic b = 1'b0);
        pc_en = en; pc_op = op; pc_target_in = PW'(tgt);
        flag_c_in = c; flag_z_in = z; flag_b_in = b;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk); @(negedge clk);
        chk("reset_pc", pc_out, 0);
        chk("reset_err", {stack_ovf, stack_unf, pc_taken}, 0);
        pc_rst = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            step(1, INC, 0);
            chk("inc_pc", pc_out, i);
            chk("inc_taken", pc_taken, 0);
        end
        // Flags and opcode churn while disabled must not move the PC.
        step(0, JMP, 'h77, 1, 1, 1);
        step(0, JC,  'h77, 1, 0, 1);
        step(0, JNZ, 'h77, 0, 0, 0);
        chk("hold_pc", pc_out, 5);

        step(1, JMP, 5); step(1, JC, 'h40, 0, 0, 0);
        chk("jc_nt_pc", pc_out, 6); chk("jc_nt_tk", pc_taken, 0);
        step(1, JMP, 5); step(1, JC, 'h40, 1, 0, 0);
        chk("jc_t_pc", pc_out, 'h40); chk("jc_t_tk", pc_taken, 1);
        step(0, INC, 0);
        chk("tk_pulse", pc_taken, 0); chk("tk_pulse_pc", pc_out, 'h40);
        step(1, JMP, 5); step(1, JZ, 'h40, 0, 1, 0);
        chk("jz_t_pc", pc_out, 'h40);
        step(1, JMP, 5); step(1, JZ, 'h40, 1, 0, 1);
        chk("jz_nt_pc", pc_out, 6);
        step(1, JMP, 5); step(1, JB, 'h40, 0, 0, 1);
        chk("jb_t_pc", pc_out, 'h40);
        step(1, JMP, 5); step(1, JNZ, 'h40, 0, 1, 0);
        chk("jnz_nt_pc", pc_out, 6); chk("jnz_nt_tk", pc_taken, 0);
        step(1, JMP, 5); step(1, JNZ, 'h40, 0, 0, 0);
        chk("jnz_t_pc", pc_out, 'h40);

        step(1, JMP, 'hFF); chk("wrap_ff", pc_out, 'hFF);
        step(1, INC, 0);
        chk("wrap_00", pc_out, 0);
        chk("wrap_err", {stack_ovf, stack_unf}, 0);

        step(1, JMP, 'h10);
        step(1, CALL, 'h20); chk("call1", pc_out, 'h20); chk("call1_tk", pc_taken, 1);
        step(1, CALL, 'h30); chk("call2", pc_out, 'h30);
        step(1, RET, 0);     chk("ret1", pc_out, 'h21);  chk("ret1_tk", pc_taken, 1);
        step(1, RET, 0);     chk("ret2", pc_out, 'h11);

        step(1, JMP, 'h80);
        for (int i = 0; i < 4; i++) step(1, CALL, 'h90 + 'h10 * i);
        chk("full_pc", pc_out, 'hC0);
        step(1, CALL, 'hD0);
        chk("ovf_pc", pc_out, 'hC1); chk("ovf_flag", stack_ovf, 1); chk("ovf_tk", pc_taken, 0);
        step(1, INC, 0);
        chk("ovf_sticky", stack_ovf, 1);
        step(1, RET, 0); chk("lifo1", pc_out, 'hB1);
        step(1, RET, 0); chk("lifo2", pc_out, 'hA1);
        step(1, RET, 0); chk("lifo3", pc_out, 'h91);
        step(1, RET, 0); chk("lifo4", pc_out, 'h81);
        step(1, RET, 0);
        chk("unf_pc", pc_out, 'h82); chk("unf_flag", stack_unf, 1); chk("unf_tk", pc_taken, 0);

        step(1, JMP, 'h50);
        step(1, CALL, 'h60);
        step(1, CALL, 'h70);
        pc_rst = 1'b0;
        step(1, CALL, 'h99);
        pc_rst = 1'b1;
        chk("rst_mid_pc", pc_out, 0);
        chk("rst_mid_err", {stack_ovf, stack_unf}, 0);
        step(1, RET, 0);
        chk("rst_clr_pc", pc_out, 1); chk("rst_clr_unf", stack_unf, 1);

        step(0, INC, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
